// File: rtl/router_pkg.sv
// Shared definitions for the 1xN router control path: FSM state encodings,
// default header address width and a ceil-log2 helper.
package router_pkg;

    localparam int unsigned ROUTER_ADDR_W = 2;

    localparam logic [3:0] DECODE_ADDR        = 4'd0;
    localparam logic [3:0] LOAD_FIRST_DATA    = 4'd1;
    localparam logic [3:0] LOAD_DATA          = 4'd2;
    localparam logic [3:0] WAIT_TILL_EMPTY    = 4'd3;
    localparam logic [3:0] CHECK_PARITY_ERROR = 4'd4;
    localparam logic [3:0] LOAD_PARITY        = 4'd5;
    localparam logic [3:0] FIFO_FULL_STATE    = 4'd6;
    localparam logic [3:0] LOAD_AFTER_FULL    = 4'd7;
    localparam logic [3:0] DROP_PKT           = 4'd8;

    function automatic int unsigned router_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Cycle counter for the WAIT_TILL_EMPTY timeout: cleared on state entry,
// counts while enabled, flags expiry on count == WAIT_TIMEOUT-1.
module router_wait_timer
    import router_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = (router_clog2(WAIT_TIMEOUT) < 1) ? 1 : router_clog2(WAIT_TIMEOUT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (32'(count) == (WAIT_TIMEOUT - 1));

endmodule

// File: rtl/router_fsm_nch.sv
// Control FSM for the 1xN packet router (NUM_CH output channels).
// Define ROUTER_FSM_TIMEOUT_EN to enable the WAIT_TILL_EMPTY timeout/drop path.
module router_fsm_nch
    import router_pkg::*;
#(
    parameter int unsigned NUM_CH       = 3,
    parameter int unsigned ADDR_W       = ROUTER_ADDR_W,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_vld,
    input  logic [ADDR_W-1:0] d_in,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] sft_rst,
    input  logic              parity_done,
    input  logic              low_pkt_vld,
    output logic [ADDR_W-1:0] dest_q,
    output logic [NUM_CH-1:0] dest_sel,
    output logic              busy,
    output logic              detect_addr,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              wr_en_reg,
    output logic              rst_int_reg,
    output logic              drop_state,
    output logic              wait_timeout
);

    localparam int unsigned ADDR_SPAN = 1 << ADDR_W;

    if (NUM_CH < 2 || NUM_CH > 16 || NUM_CH > ADDR_SPAN || WAIT_TIMEOUT < 1) begin : g_bad_params
        $error("router_fsm_nch: illegal NUM_CH/ADDR_W/WAIT_TIMEOUT combination");
    end

    logic [3:0]           state;
    logic [3:0]           next_state;
    logic [ADDR_SPAN-1:0] empty_pad;
    logic [ADDR_SPAN-1:0] sft_pad;
    logic                 timer_expire;

    // Pad per-channel flags to the full address span so any address indexes safely.
    always_comb begin
        empty_pad = '0;
        sft_pad   = '0;
        empty_pad[NUM_CH-1:0] = fifo_empty;
        sft_pad[NUM_CH-1:0]   = sft_rst;
    end

    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDR: begin
                if (pkt_vld) begin
                    if (32'(d_in) >= NUM_CH)  next_state = DROP_PKT;
                    else if (empty_pad[d_in]) next_state = LOAD_FIRST_DATA;
                    else                      next_state = WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (empty_pad[dest_q])  next_state = LOAD_FIRST_DATA;
                else if (timer_expire)  next_state = DROP_PKT;
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)     next_state = FIFO_FULL_STATE;
                else if (!pkt_vld) next_state = LOAD_PARITY;
            end
            LOAD_PARITY:        next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDR;
            FIFO_FULL_STATE: begin
                if (!fifo_full) next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)      next_state = DECODE_ADDR;
                else if (low_pkt_vld) next_state = LOAD_PARITY;
                else                  next_state = LOAD_DATA;
            end
            DROP_PKT: begin
                if (!pkt_vld) next_state = DECODE_ADDR;
            end
            default: next_state = DECODE_ADDR;
        endcase
        // Soft reset of the selected channel aborts any in-flight packet.
        if (sft_pad[dest_q] && state != DECODE_ADDR && state != DROP_PKT) begin
            next_state = DECODE_ADDR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= DECODE_ADDR;
            dest_q <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDR && pkt_vld) dest_q <= d_in;
        end
    end

`ifdef ROUTER_FSM_TIMEOUT_EN
    router_wait_timer #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (next_state == WAIT_TILL_EMPTY && state != WAIT_TILL_EMPTY),
        .enable (state == WAIT_TILL_EMPTY),
        .expire (timer_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wait_timeout <= 1'b0;
        else     wait_timeout <= (state == WAIT_TILL_EMPTY) && (next_state == DROP_PKT);
    end
`else
    assign timer_expire = 1'b0;
    assign wait_timeout = 1'b0;
`endif

    always_comb begin
        dest_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(dest_q) == i) dest_sel[i] = 1'b1;
        end
    end

    assign detect_addr = (state == DECODE_ADDR);
    assign lfd_state   = (state == LOAD_FIRST_DATA);
    assign ld_state    = (state == LOAD_DATA);
    assign laf_state   = (state == LOAD_AFTER_FULL);
    assign full_state  = (state == FIFO_FULL_STATE);
    assign rst_int_reg = (state == CHECK_PARITY_ERROR);
    assign drop_state  = (state == DROP_PKT);
    assign wr_en_reg   = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL) || (state == LOAD_PARITY);
    assign busy        = (state == LOAD_FIRST_DATA) || (state == WAIT_TILL_EMPTY)
                      || (state == LOAD_PARITY) || (state == FIFO_FULL_STATE)
                      || (state == LOAD_AFTER_FULL) || (state == CHECK_PARITY_ERROR);

endmodule
